// File: rtl/led_shift_driver_if.sv
// ---------------------------------------------------------------------------
// led_shift_driver_if
// Groups the frame-load handshake and the 74HC595 chain pins of
// led_shift_driver.
//   load        : one-cycle strobe, capture data and start a transfer
//   data        : WIDTH-bit frame to display
//   brightness  : PWM_BITS-bit brightness, 0 = dark, all-ones = fully on
//   sr_data     : serial data to the chain
//   sr_clk      : shift clock, chain samples sr_data on the rising edge
//   sr_latch    : storage-register latch pulse
//   sr_oe_n     : active-low output enable (PWM dimming)
//   busy        : transfer in progress
//   done        : one-cycle pulse when a latch phase completes
// master = frame producer side, slave = the driver.
// ---------------------------------------------------------------------------
interface led_shift_driver_if #(
   parameter int WIDTH    = 16,
   parameter int PWM_BITS = 4
);
   logic                load;
   logic [WIDTH-1:0]    data;
   logic [PWM_BITS-1:0] brightness;
   logic                sr_data;
   logic                sr_clk;
   logic                sr_latch;
   logic                sr_oe_n;
   logic                busy;
   logic                done;

   modport master (
      output load, data, brightness,
      input  sr_data, sr_clk, sr_latch, sr_oe_n, busy, done
   );

   modport slave (
      input  load, data, brightness,
      output sr_data, sr_clk, sr_latch, sr_oe_n, busy, done
   );
endinterface

// File: rtl/led_shift_driver.sv
// ---------------------------------------------------------------------------
// led_shift_driver
// Serializes each loaded frame onto a 74HC595-style chain and dims the
// displayed LEDs with PWM on the active-low output enable.
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : led_shift_driver_if.slave (load/data/brightness in,
//          sr_data/sr_clk/sr_latch/sr_oe_n/busy/done out)
// Each bit spends CLK_DIV cycles with sr_clk low (data set up) and CLK_DIV
// cycles with sr_clk high, followed by a CLK_DIV-cycle latch pulse.
// A load arriving while busy is parked in a single-depth pending register
// (latest wins) and started straight from the latch phase.
// ---------------------------------------------------------------------------
module led_shift_driver #(
   parameter int WIDTH     = 16,
   parameter int CLK_DIV   = 4,
   parameter int PWM_BITS  = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic          clk,
   input  logic          rst,
   led_shift_driver_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int DIV_W = $clog2(CLK_DIV + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOW,
      S_HIGH,
      S_LATCH
   } state_t;

   state_t              r_state,     w_state;
   logic [DIV_W-1:0]    r_div,       w_div;
   logic [CNT_W-1:0]    r_cnt,       w_cnt;
   logic [WIDTH-1:0]    r_shift,     w_shift;
   logic                r_pend,      w_pend;
   logic [WIDTH-1:0]    r_pend_data, w_pend_data;
   logic                r_sr_data,   w_sr_data;
   logic                r_done,      w_done;
   logic                r_valid,     w_valid;
   logic [PWM_BITS-1:0] r_pwm,       w_pwm;

   logic                w_div_end;
   logic [WIDTH-1:0]    w_shifted;
   logic [WIDTH-1:0]    w_start_data;
   logic                w_lit;

   // Bit that goes out first from a freshly loaded / shifted register.
   function automatic logic first_bit(input logic [WIDTH-1:0] v);
      if (MSB_FIRST != 0) return v[WIDTH-1];
      else                return v[0];
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_div       <= '0;
         r_cnt       <= '0;
         r_shift     <= '0;
         r_pend      <= 1'b0;
         r_pend_data <= '0;
         r_sr_data   <= 1'b0;
         r_done      <= 1'b0;
         r_valid     <= 1'b0;
         r_pwm       <= '0;
      end else begin
         r_state     <= w_state;
         r_div       <= w_div;
         r_cnt       <= w_cnt;
         r_shift     <= w_shift;
         r_pend      <= w_pend;
         r_pend_data <= w_pend_data;
         r_sr_data   <= w_sr_data;
         r_done      <= w_done;
         r_valid     <= w_valid;
         r_pwm       <= w_pwm;
      end
   end

   always_comb begin
      w_state      = r_state;
      w_div        = r_div;
      w_cnt        = r_cnt;
      w_shift      = r_shift;
      w_pend       = r_pend;
      w_pend_data  = r_pend_data;
      w_sr_data    = r_sr_data;
      w_done       = 1'b0;
      w_valid      = r_valid;
      w_pwm        = r_pwm + PWM_BITS'(1);

      w_div_end    = (r_div == DIV_W'(CLK_DIV - 1));
      w_shifted    = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);
      // A load coinciding with the latch exit is newer than any parked frame.
      w_start_data = bus.load ? bus.data : r_pend_data;

      // Any load outside IDLE is parked; the latch-exit branch below
      // overrides this when it starts the frame immediately.
      if (bus.load && (r_state != S_IDLE)) begin
         w_pend      = 1'b1;
         w_pend_data = bus.data;
      end

      case (r_state)
         S_IDLE: begin
            if (bus.load) begin
               w_shift   = bus.data;
               w_cnt     = '0;
               w_div     = '0;
               w_sr_data = first_bit(bus.data);
               w_state   = S_LOW;
            end
         end

         S_LOW: begin
            if (w_div_end) begin
               w_div   = '0;
               w_state = S_HIGH;
            end else begin
               w_div   = r_div + DIV_W'(1);
            end
         end

         S_HIGH: begin
            if (w_div_end) begin
               w_div   = '0;
               w_shift = w_shifted;
               w_cnt   = r_cnt + CNT_W'(1);
               if ((r_cnt + CNT_W'(1)) == CNT_W'(WIDTH)) begin
                  w_state = S_LATCH;
               end else begin
                  w_sr_data = first_bit(w_shifted);
                  w_state   = S_LOW;
               end
            end else begin
               w_div   = r_div + DIV_W'(1);
            end
         end

         S_LATCH: begin
            if (w_div_end) begin
               w_div   = '0;
               w_done  = 1'b1;
               w_valid = 1'b1;
               if (bus.load || r_pend) begin
                  w_pend    = 1'b0;
                  w_shift   = w_start_data;
                  w_cnt     = '0;
                  w_sr_data = first_bit(w_start_data);
                  w_state   = S_LOW;
               end else begin
                  w_state   = S_IDLE;
               end
            end else begin
               w_div   = r_div + DIV_W'(1);
            end
         end

         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   // Full brightness is forced on so all-ones never leaves a dark slot.
   assign w_lit = (bus.brightness == '1) || (r_pwm < bus.brightness);

   assign bus.sr_data  = r_sr_data;
   assign bus.sr_clk   = (r_state == S_HIGH);
   assign bus.sr_latch = (r_state == S_LATCH);
   assign bus.sr_oe_n  = ~(w_lit & r_valid);
   assign bus.busy     = (r_state != S_IDLE);
   assign bus.done     = r_done;

endmodule

// File: tb/tb_led_shift_driver.sv
// ---------------------------------------------------------------------------
// tb_led_shift_driver
// Two driver instances (CLK_DIV=2): dut0 MSB-first, dut1 LSB-first.
// Transfer vectors and PWM vectors are table-driven; back-to-back loads and
// reset mid-transfer are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_led_shift_driver;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   led_shift_driver_if #(.WIDTH(16), .PWM_BITS(4)) if0 ();
   led_shift_driver_if #(.WIDTH(16), .PWM_BITS(4)) if1 ();

   led_shift_driver #(.WIDTH(16), .CLK_DIV(2), .PWM_BITS(4), .MSB_FIRST(1)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (if0)
   );

   led_shift_driver #(.WIDTH(16), .CLK_DIV(2), .PWM_BITS(4), .MSB_FIRST(0)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Bit collectors: first sampled bit ends up in the MSB of the word.
   logic [15:0] mw [2];
   int          rc [2];
   logic [15:0] q0 [$];

   always @(posedge if0.sr_clk) begin
      mw[0] = {mw[0][14:0], if0.sr_data};
      rc[0] = rc[0] + 1;
   end

   always @(posedge if1.sr_clk) begin
      mw[1] = {mw[1][14:0], if1.sr_data};
      rc[1] = rc[1] + 1;
   end

   always @(posedge clk) begin
      if (if0.done === 1'b1) begin
         q0.push_back(mw[0]);
         mw[0] = '0;
         rc[0] = 0;
      end
      if (if1.done === 1'b1) begin
         mw[1] = '0;
         rc[1] = 0;
      end
   end

   task automatic drive(input int d, input logic ld, input logic [15:0] dt);
      if (d == 0) begin
         if0.load = ld;
         if0.data = dt;
      end else begin
         if1.load = ld;
         if1.data = dt;
      end
   endtask

   function automatic logic g_done(input int d);  return (d == 0) ? if0.done     : if1.done;     endfunction
   function automatic logic g_busy(input int d);  return (d == 0) ? if0.busy     : if1.busy;     endfunction
   function automatic logic g_latch(input int d); return (d == 0) ? if0.sr_latch : if1.sr_latch; endfunction
   function automatic logic g_sclk(input int d);  return (d == 0) ? if0.sr_clk   : if1.sr_clk;   endfunction
   function automatic logic g_oe(input int d);    return (d == 0) ? if0.sr_oe_n  : if1.sr_oe_n;  endfunction
   function automatic logic g_sdat(input int d);  return (d == 0) ? if0.sr_data  : if1.sr_data;  endfunction

   task automatic chk_reset_outputs(input int d, input string nm);
      chk({nm, "_sr_data"},  {31'd0, g_sdat(d)},  32'd0);
      chk({nm, "_sr_clk"},   {31'd0, g_sclk(d)},  32'd0);
      chk({nm, "_sr_latch"}, {31'd0, g_latch(d)}, 32'd0);
      chk({nm, "_sr_oe_n"},  {31'd0, g_oe(d)},    32'd1);
      chk({nm, "_busy"},     {31'd0, g_busy(d)},  32'd0);
      chk({nm, "_done"},     {31'd0, g_done(d)},  32'd0);
   endtask

   // One isolated transfer: load edge N, done expected after edge N+66.
   task automatic transfer(input int d, input logic [15:0] dt, input logic [15:0] exp,
                           input string nm);
      int cyc;
      int lat;
      @(negedge clk);
      mw[d] = '0;
      rc[d] = 0;
      drive(d, 1'b1, dt);
      @(posedge clk);
      @(negedge clk);
      drive(d, 1'b0, 16'h0000);
      cyc = 0;
      lat = 0;
      do begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (g_latch(d)) lat++;
      end while (!g_done(d) && cyc < 300);
      chk({nm, "_done_cycle"}, cyc, 32'd66);
      chk({nm, "_bits"},       {16'd0, mw[d]}, {16'd0, exp});
      chk({nm, "_rises"},      rc[d], 32'd16);
      chk({nm, "_latch_len"},  lat, 32'd2);
      chk({nm, "_busy_at_done"}, {31'd0, g_busy(d)}, 32'd0);
   endtask

   typedef struct {
      int          d;
      logic [15:0] data;
      logic [15:0] exp_seq;
   } xfer_t;

   typedef struct {
      logic [3:0] bright;
      int         exp_low;
   } pwm_t;

   xfer_t xv [5];
   pwm_t  pv [5];

   initial begin
      int bad;
      int cyc;
      int dn;
      int gap;
      int dcyc [2];
      logic [15:0] w0;
      logic [15:0] w1;

      xv[0] = '{0, 16'hA5C3, 16'hA5C3};
      xv[1] = '{0, 16'h00FF, 16'h00FF};
      xv[2] = '{1, 16'h0001, 16'h8000};
      xv[3] = '{1, 16'hA5C3, 16'hC3A5};
      xv[4] = '{1, 16'h00FF, 16'hFF00};

      pv[0] = '{4'd4,  4};
      pv[1] = '{4'd0,  0};
      pv[2] = '{4'd15, 16};
      pv[3] = '{4'd8,  8};
      pv[4] = '{4'd1,  1};

      mw[0] = '0; mw[1] = '0; rc[0] = 0; rc[1] = 0;
      rst = 1'b1;
      drive(0, 1'b0, 16'h0000);
      drive(1, 1'b0, 16'h0000);
      if0.brightness = 4'd15;
      if1.brightness = 4'd15;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs(0, "rst0");
      chk_reset_outputs(1, "rst1");
      rst = 1'b0;

      // No load: chain stays quiet and blank even at full brightness.
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++)
            if (g_busy(d) || g_sclk(d) || g_latch(d) || !g_oe(d)) bad++;
      end
      chk("idle_quiet", bad, 32'd0);

      for (int i = 0; i < 5; i++)
         transfer(xv[i].d, xv[i].data, xv[i].exp_seq, $sformatf("xfer%0d", i));

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if0.brightness = pv[i].bright;
         bad = 0;
         repeat (16) begin
            @(negedge clk);
            if (!if0.sr_oe_n) bad++;
         end
         chk($sformatf("pwm_b%0d", pv[i].bright), bad, pv[i].exp_low);
      end

      // Back-to-back: 1234 is overwritten by FFFF before the first frame ends.
      q0.delete();
      @(negedge clk);
      mw[0] = '0;
      rc[0] = 0;
      drive(0, 1'b1, 16'h00FF);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, 16'h0000);
      cyc = 0; dn = 0; gap = 0; dcyc[0] = -1; dcyc[1] = -1;
      repeat (200) begin
         if (cyc == 20)      drive(0, 1'b1, 16'h1234);
         else if (cyc == 30) drive(0, 1'b1, 16'hFFFF);
         else                drive(0, 1'b0, 16'h0000);
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (if0.done) begin
            if (dn < 2) dcyc[dn] = cyc;
            dn++;
         end
         if (dn < 2 && !if0.busy) gap++;
      end
      chk("b2b_done_count", dn, 32'd2);
      chk("b2b_done1_cycle", dcyc[0], 32'd66);
      chk("b2b_done2_cycle", dcyc[1], 32'd132);
      chk("b2b_busy_gap", gap, 32'd0);
      chk("b2b_frames", q0.size(), 32'd2);
      w0 = (q0.size() > 0) ? q0[0] : 16'hxxxx;
      w1 = (q0.size() > 1) ? q0[1] : 16'hxxxx;
      chk("b2b_frame0", {16'd0, w0}, {16'd0, 16'h00FF});
      chk("b2b_frame1", {16'd0, w1}, {16'd0, 16'hFFFF});

      // Reset mid-transfer with a frame pending.
      if0.brightness = 4'd15;
      @(negedge clk);
      mw[0] = '0;
      rc[0] = 0;
      drive(0, 1'b1, 16'hA5C3);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, 16'h0000);
      cyc = 0;
      while (rc[0] < 7 && cyc < 300) begin
         if (cyc == 3) drive(0, 1'b1, 16'h1234);
         else          drive(0, 1'b0, 16'h0000);
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      drive(0, 1'b0, 16'h0000);
      chk("mid_rst_rises", rc[0], 32'd7);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_reset_outputs(0, "mid_rst");
      rst = 1'b0;
      bad = 0;
      repeat (150) begin
         @(negedge clk);
         if (if0.done || if0.busy || !if0.sr_oe_n) bad++;
      end
      chk("mid_rst_pending_dropped", bad, 32'd0);
      transfer(0, 16'hA5C3, 16'hA5C3, "after_rst");
      chk("after_rst_lit", {31'd0, if0.sr_oe_n}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
